// File: rtl/cpu_pkg.sv
// Shared definitions for the 8-bit load/store CPU: widths,
// opcodes, controller states and opcode-class helpers.
package cpu_pkg;

   localparam int DATA_W = 8;
   localparam int ADDR_W = 5;

   localparam logic [3:0] OP_NOP  = 4'h0;
   localparam logic [3:0] OP_ADD  = 4'h1;
   localparam logic [3:0] OP_SUB  = 4'h2;
   localparam logic [3:0] OP_AND  = 4'h3;
   localparam logic [3:0] OP_OR   = 4'h4;
   localparam logic [3:0] OP_XOR  = 4'h5;
   localparam logic [3:0] OP_ADDI = 4'h6;
   localparam logic [3:0] OP_SHL  = 4'h7;
   localparam logic [3:0] OP_SHR  = 4'h8;
   localparam logic [3:0] OP_LD   = 4'h9;
   localparam logic [3:0] OP_ST   = 4'hA;
   localparam logic [3:0] OP_JZ   = 4'hB;
   localparam logic [3:0] OP_JMP  = 4'hC;
   localparam logic [3:0] OP_LI   = 4'hD;
   localparam logic [3:0] OP_MOV  = 4'hE;
   localparam logic [3:0] OP_HLT  = 4'hF;

   typedef enum logic [2:0] {
      S_FETCH,
      S_DECODE,
      S_EXEC,
      S_WB,
      S_HALT
   } state_t;

   function automatic logic writes_reg(input logic [3:0] op);
      return (op inside {[OP_ADD:OP_LD], OP_LI, OP_MOV});
   endfunction

   function automatic logic sets_zero(input logic [3:0] op);
      return (op inside {[OP_ADD:OP_SHR], OP_LI, OP_MOV});
   endfunction

endpackage

// File: rtl/top_cpu_units.sv
// Datapath units of top_cpu: PC, IR, register file, RAM, ALU.
// RAM powers up all-zero and is not touched by reset.
module cpu_pc
   import cpu_pkg::*;
(
   input  logic              clk,
   input  logic              rst,
   input  logic              inc_i,
   input  logic              load_i,
   input  logic [ADDR_W-1:0] target_i,
   output logic [ADDR_W-1:0] pc_out
);
   always_ff @(posedge clk or posedge rst) begin
      if (rst)         pc_out <= '0;
      else if (load_i) pc_out <= target_i;
      else if (inc_i)  pc_out <= pc_out + 5'd1;
   end
endmodule

module cpu_ir
   import cpu_pkg::*;
(
   input  logic              clk,
   input  logic              rst,
   input  logic              load_i,
   input  logic [DATA_W-1:0] instr_i,
   output logic [DATA_W-1:0] instruction_out
);
   always_ff @(posedge clk or posedge rst) begin
      if (rst)         instruction_out <= '0;
      else if (load_i) instruction_out <= instr_i;
   end
endmodule

module cpu_regfile
   import cpu_pkg::*;
(
   input  logic              clk,
   input  logic              rst,
   input  logic              we_i,
   input  logic [1:0]        waddr_i,
   input  logic [DATA_W-1:0] wdata_i,
   input  logic [1:0]        ra_i,
   input  logic [1:0]        rb_i,
   output logic [DATA_W-1:0] ra_o,
   output logic [DATA_W-1:0] rb_o
);
   logic [DATA_W-1:0] regfile [0:3];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < 4; i++) regfile[i] <= '0;
      end else if (we_i) begin
         regfile[waddr_i] <= wdata_i;
      end
   end

   assign ra_o = regfile[ra_i];
   assign rb_o = regfile[rb_i];
endmodule

module cpu_ram
   import cpu_pkg::*;
(
   input  logic              clk,
   input  logic              we_i,
   input  logic [ADDR_W-1:0] waddr_i,
   input  logic [DATA_W-1:0] wdata_i,
   input  logic [ADDR_W-1:0] raddr_a_i,
   input  logic [ADDR_W-1:0] raddr_b_i,
   output logic [DATA_W-1:0] rdata_a_o,
   output logic [DATA_W-1:0] rdata_b_o
);
   logic [DATA_W-1:0] mem [0:31] = '{default: 8'h00};

   always_ff @(posedge clk) begin
      if (we_i) mem[waddr_i] <= wdata_i;
   end

   assign rdata_a_o = mem[raddr_a_i];
   assign rdata_b_o = mem[raddr_b_i];
endmodule

module cpu_alu
   import cpu_pkg::*;
(
   input  logic [DATA_W-1:0] a_i,
   input  logic [DATA_W-1:0] b_i,
   input  logic [1:0]        imm2,
   input  logic              immsel_i,
   input  logic [3:0]        opcode_i,
   output logic [DATA_W-1:0] result_o,
   output logic              zero_o
);
   logic [DATA_W-1:0] b_op;

   assign b_op = immsel_i ? {6'b0, imm2} : b_i;

   always_comb begin
      result_o = a_i;
      case (opcode_i)
         OP_ADD, OP_ADDI: result_o = a_i + b_op;
         OP_SUB:          result_o = a_i - b_op;
         OP_AND:          result_o = a_i & b_op;
         OP_OR:           result_o = a_i | b_op;
         OP_XOR:          result_o = a_i ^ b_op;
         OP_SHL:          result_o = {a_i[6:0], 1'b0};
         OP_SHR:          result_o = {1'b0, a_i[7:1]};
         OP_LI, OP_MOV:   result_o = b_op;
         OP_NOP, OP_HLT:  result_o = a_i;
         default:         result_o = a_i;
      endcase
   end

   assign zero_o = (result_o == '0);
endmodule

// File: rtl/top_cpu.sv
// 8-bit load/store CPU top: power-on reset, 4-state controller
// and datapath wiring. Each instruction takes four clocks.
module top_cpu
   import cpu_pkg::*;
(
   input logic clk
);
   // Power-on reset: high from time 0, released by the first clk edge.
   logic por_done_q = 1'b0;
   logic reset;

   always_ff @(posedge clk) por_done_q <= 1'b1;
   assign reset = ~por_done_q;

   state_t state_q, state_d;

   logic [ADDR_W-1:0] pc_w;
   logic [DATA_W-1:0] ir_w;
   logic [DATA_W-1:0] mem_fetch, mem_ld;
   logic [DATA_W-1:0] ra, rb;
   logic [DATA_W-1:0] alu_res;
   logic              alu_zero;
   logic [DATA_W-1:0] alu_out_reg;
   logic              zero_flag;
   logic [3:0]        opcode;
   logic [1:0]        reg_dest, rs;
   logic              fetch_en, pc_load, mem_we;
   logic              reg_write_en, immsel;
   logic [DATA_W-1:0] reg_data_in;

   assign opcode   = ir_w[7:4];
   assign reg_dest = ir_w[3:2];
   assign rs       = ir_w[1:0];
   assign immsel   = (opcode == OP_ADDI) || (opcode == OP_LI);
   assign reg_data_in = (opcode == OP_LD) ? mem_ld : alu_out_reg;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) state_q <= S_FETCH;
      else       state_q <= state_d;
   end

   always_comb begin
      state_d      = state_q;
      fetch_en     = 1'b0;
      reg_write_en = 1'b0;
      mem_we       = 1'b0;
      pc_load      = 1'b0;
      unique case (state_q)
         S_FETCH: begin
            fetch_en = 1'b1;
            state_d  = S_DECODE;
         end
         S_DECODE: state_d = S_EXEC;
         S_EXEC:   state_d = S_WB;
         S_WB: begin
            reg_write_en = writes_reg(opcode);
            mem_we       = (opcode == OP_ST);
            pc_load      = (opcode == OP_JMP) ||
                           ((opcode == OP_JZ) && zero_flag);
            state_d      = (opcode == OP_HLT) ? S_HALT : S_FETCH;
         end
         S_HALT:   state_d = S_HALT;
         default:  state_d = S_FETCH;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         alu_out_reg <= '0;
         zero_flag   <= 1'b0;
      end else if (state_q == S_EXEC) begin
         alu_out_reg <= alu_res;
         if (sets_zero(opcode)) zero_flag <= alu_zero;
      end
   end

   cpu_pc pc (
      .clk      (clk),
      .rst      (reset),
      .inc_i    (fetch_en),
      .load_i   (pc_load),
      .target_i (ra[4:0]),
      .pc_out   (pc_w)
   );

   cpu_ir ir (
      .clk             (clk),
      .rst             (reset),
      .load_i          (fetch_en),
      .instr_i         (mem_fetch),
      .instruction_out (ir_w)
   );

   cpu_regfile regfile (
      .clk     (clk),
      .rst     (reset),
      .we_i    (reg_write_en),
      .waddr_i (reg_dest),
      .wdata_i (reg_data_in),
      .ra_i    (reg_dest),
      .rb_i    (rs),
      .ra_o    (ra),
      .rb_o    (rb)
   );

   cpu_ram ram (
      .clk       (clk),
      .we_i      (mem_we),
      .waddr_i   (ra[4:0]),
      .wdata_i   (rb),
      .raddr_a_i (pc_w),
      .raddr_b_i (rb[4:0]),
      .rdata_a_o (mem_fetch),
      .rdata_b_o (mem_ld)
   );

   cpu_alu alu (
      .a_i      (ra),
      .b_i      (rb),
      .imm2     (rs),
      .immsel_i (immsel),
      .opcode_i (opcode),
      .result_o (alu_res),
      .zero_o   (alu_zero)
   );
endmodule

// File: tb/tb_top_cpu.sv
// Bench for top_cpu: one directed program checked against an
// instruction-level model every cycle, plus literal anchors.
module tb_top_cpu;
   logic clk;

   top_cpu dut (.clk(clk));

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   localparam logic [7:0] PROG [32] = '{
      8'hD7, 8'hDA, 8'h16, 8'hED, 8'h7C, 8'h2A, 8'hBC, 8'hC0,
      8'hF0, 8'hF0, 8'hA7, 8'h91, 8'hD9, 8'hB8, 8'h20, 8'h22,
      8'h61, 8'h43, 8'h51, 8'h33, 8'h80, 8'h51, 8'h22, 8'h80,
      8'h80, 8'h80, 8'h2A, 8'hC8, 8'h00, 8'h00, 8'h00, 8'hF0
   };

   int total = 0;
   int bad   = 0;

   logic [7:0] m_r   [4];
   logic [7:0] m_mem [32];
   logic [4:0] m_pc;
   logic [7:0] m_ir;
   logic       m_z;
   logic       m_halt;

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h", nm, act, exp);
      end
   endtask

   // One whole instruction at ISA level.
   task automatic step();
      logic [7:0] ins, res;
      logic [3:0] op;
      logic [1:0] d, s;
      logic       upd;
      if (m_halt) return;
      ins  = m_mem[m_pc];
      m_ir = ins;
      m_pc = m_pc + 5'd1;
      op = ins[7:4];
      d  = ins[3:2];
      s  = ins[1:0];
      res = 8'h00;
      upd = 1'b0;
      case (op)
         4'h1: begin res = m_r[d] + m_r[s]; upd = 1'b1; end
         4'h2: begin res = m_r[d] - m_r[s]; upd = 1'b1; end
         4'h3: begin res = m_r[d] & m_r[s]; upd = 1'b1; end
         4'h4: begin res = m_r[d] | m_r[s]; upd = 1'b1; end
         4'h5: begin res = m_r[d] ^ m_r[s]; upd = 1'b1; end
         4'h6: begin res = m_r[d] + {6'b0, s}; upd = 1'b1; end
         4'h7: begin res = m_r[d] << 1; upd = 1'b1; end
         4'h8: begin res = m_r[d] >> 1; upd = 1'b1; end
         4'h9: m_r[d] = m_mem[m_r[s][4:0]];
         4'hA: m_mem[m_r[d][4:0]] = m_r[s];
         4'hB: if (m_z) m_pc = m_r[d][4:0];
         4'hC: m_pc = m_r[d][4:0];
         4'hD: begin res = {6'b0, s}; upd = 1'b1; end
         4'hE: begin res = m_r[s]; upd = 1'b1; end
         4'hF: m_halt = 1'b1;
         default: ;
      endcase
      if (upd) begin
         m_r[d] = res;
         m_z    = (res == 8'h00);
      end
   endtask

   function automatic logic is_wr(input logic [3:0] op);
      return (op >= 4'h1 && op <= 4'h9) || op == 4'hD || op == 4'hE;
   endfunction

   task automatic lit(input int n);
      case (n)
         1: begin
            chk("pwr_ir", 32'(dut.ir.instruction_out), 32'hD7);
            chk("pwr_pc", 32'(dut.pc.pc_out), 32'd1);
         end
         3: chk("add_r1", 32'(dut.regfile.regfile[1]), 32'd5);
         6: begin
            chk("sub_r2", 32'(dut.regfile.regfile[2]), 32'd0);
            chk("sub_z", 32'(dut.zero_flag), 32'd1);
         end
         7:  chk("jz_taken_pc", 32'(dut.pc.pc_out), 32'd10);
         9: begin
            chk("ld_r0", 32'(dut.regfile.regfile[0]), 32'd10);
            chk("st_mem5", 32'(dut.ram.mem[5]), 32'd10);
         end
         11: chk("jz_not_pc", 32'(dut.pc.pc_out), 32'd14);
         14: begin
            chk("addi_wrap_r0", 32'(dut.regfile.regfile[0]), 32'd0);
            chk("addi_wrap_z", 32'(dut.zero_flag), 32'd1);
         end
         25: chk("jmp0_pc", 32'(dut.pc.pc_out), 32'd0);
         32: chk("jz2_not_pc", 32'(dut.pc.pc_out), 32'd7);
         33: chk("jmp31_pc", 32'(dut.pc.pc_out), 32'd31);
         default: ;
      endcase
      if (n >= 34) begin
         chk("halt_pc", 32'(dut.pc.pc_out), 32'd0);
         chk("halt_ir", 32'(dut.ir.instruction_out), 32'hF0);
         chk("halt_r0", 32'(dut.regfile.regfile[0]), 32'd31);
      end
   endtask

   initial begin
      logic [3:0] cur_op;
      logic [1:0] cur_rd;
      logic       cur_ok;
      logic       exp_we;
      int         ph;
      cur_op = 4'h0;
      cur_rd = 2'd0;
      cur_ok = 1'b0;
      #1;
      for (int i = 0; i < 32; i++) begin
         dut.ram.mem[i] = PROG[i];
         m_mem[i] = PROG[i];
      end
      for (int i = 0; i < 4; i++) m_r[i] = 8'h00;
      m_pc = 5'd0;
      m_ir = 8'h00;
      m_z = 1'b0;
      m_halt = 1'b0;

      for (int k = 0; k <= 152; k++) begin
         @(negedge clk);
         ph = k % 4;
         if (ph == 0) begin
            chk("pc", 32'(dut.pc.pc_out), 32'(m_pc));
            chk("ir", 32'(dut.ir.instruction_out), 32'(m_ir));
            chk("zf", 32'(dut.zero_flag), 32'(m_z));
            for (int r = 0; r < 4; r++)
               chk($sformatf("r%0d", r),
                   32'(dut.regfile.regfile[r]), 32'(m_r[r]));
            for (int a = 0; a < 32; a++)
               chk($sformatf("mem%0d", a),
                   32'(dut.ram.mem[a]), 32'(m_mem[a]));
            if (k == 0)
               chk("rst_alu_out", 32'(dut.alu_out_reg), 32'd0);
            lit(k / 4);
            cur_ok = !m_halt;
            cur_op = m_mem[m_pc][7:4];
            cur_rd = m_mem[m_pc][3:2];
            step();
         end else begin
            chk("immsel", 32'(dut.immsel),
                32'(cur_ok && (cur_op == 4'h6 || cur_op == 4'hD)));
         end
         exp_we = cur_ok && ph == 3 && is_wr(cur_op);
         chk("reg_write_en", 32'(dut.reg_write_en), 32'(exp_we));
         if (exp_we) begin
            chk("reg_dest", 32'(dut.reg_dest), 32'(cur_rd));
            chk("reg_data_in", 32'(dut.reg_data_in),
                32'(m_r[cur_rd]));
         end
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/top_cpu.md
# top_cpu

Complete 8-bit accumulator-less load/store CPU: program counter, instruction register, 4×8 register file, ALU with zero flag, 32×8 unified program/data RAM and a 4-state controller. Self-contained: only a clock enters; reset is generated internally at power-up. Each instruction takes exactly 4 clocks; HLT freezes all architectural state.

## Interface
- Parameters: none (RAM depth 32, data width 8, 4 registers fixed).
- clk  input  1  system clock, rising-edge active.
- reset  internal net  1  asynchronous active-high reset to all state. It is produced by an internal power-on generator, asserted from time 0 and released at the first rising clk edge. There is no external reset pin.
- Debug-visible internal nets, probed hierarchically by benches:
  - pc.pc_out[4:0], ir.instruction_out[7:0], regfile.regfile[0:3][7:0], ram.mem[0:31][7:0].
  - reg_write_en, immsel, zero_flag, reg_dest[1:0], alu.imm2[1:0], alu_out_reg[7:0], reg_data_in[7:0].

## Operation
- Instruction format: [7:4] opcode, [3:2] rd, [1:0] rs or imm2.
- Opcodes:
  - 0 NOP
  - 1 ADD rd=rd+rs
  - 2 SUB rd=rd−rs
  - 3 AND
  - 4 OR
  - 5 XOR
  - 6 ADDI rd=rd+imm2
  - 7 SHL rd=rd<<1
  - 8 SHR rd=rd>>1 (logical)
  - 9 LD rd=mem[rs[4:0]]
  - A ST mem[rd[4:0]]=rs
  - B JZ: if zero_flag then PC=rd[4:0]
  - C JMP PC=rd[4:0]
  - D LI rd=imm2
  - E MOV rd=rs
  - F HLT
- Arithmetic is modulo 256; carry is discarded. SUB wraps (0−1=255).
- zero_flag is updated only by opcodes 1–8 and D, E, and is set when the 8-bit result is 0. LD, ST, jumps, NOP and HLT leave it unchanged.
- immsel=1 for ADDI/LI; the ALU B operand is then {6'b0, imm2}.
- reg_write_en is high only in WRITEBACK of opcodes 1–9, D, E.
- reg_dest=rd. reg_data_in is mem data for LD, otherwise alu_out_reg.
- Controller states:
  - FETCH: IR<=mem[PC], PC<=PC+1.
  - DECODE: operand read, control decode.
  - EXECUTE: alu_out_reg and zero_flag latched.
  - WRITEBACK: register write, RAM store or PC load.
  - Sequence is FETCH→DECODE→EXECUTE→WRITEBACK→FETCH.
- HLT enters HALT in WRITEBACK; HALT is absorbing until reset. In HALT: PC, IR, registers and RAM are frozen and reg_write_en=0.
- PC wraps 31→0.
- A jump target overrides the FETCH increment.
- A store to the address of a not-yet-fetched instruction modifies the program (self-modifying code allowed).

## Timing
- Reset values: PC=0, IR=0, registers=0, zero_flag=0, alu_out_reg=0, state=FETCH, reg_write_en=0. RAM is not cleared.
- Reset assertion takes effect immediately (asynchronous); the first FETCH occurs at the first rising edge after release.
- Instruction n (1-based) is fully retired 4n clocks after reset release. Register, RAM and PC effects are visible after the WRITEBACK edge.
- LD/ST access RAM combinationally-addressed and synchronously written (write on the WRITEBACK edge).
- Register reads during DECODE see the value written by the previous instruction (no hazard, since execution is serial).

## Configuration
- RAM_INIT_EN defined: ram.mem is loaded at elaboration from binary text file "program.mem" via $readmemb.
- RAM_INIT_EN undefined: RAM powers up all-zero, so the CPU executes NOPs and PC wraps continuously.

## Structure
- Shared package cpu_pkg holds:
  - opcode localparams (OP_NOP..OP_HLT)
  - state encoding (S_FETCH, S_DECODE, S_EXEC, S_WB, S_HALT)
  - widths (DATA_W=8, ADDR_W=5)
- Instance names are fixed for debug probing: pc, ir, regfile, ram, alu.
- The natural standalone sub-module is alu (operands a, b, opcode; outputs result and zero). The others are small registers and may be simple modules.

## Test plan
- Power-up: after reset release, PC=0, R0–R3=0, IR=0. After 4 clocks IR=mem[0] and PC=1.
- Program LI R1,3; LI R2,2; ADD R1,R2; SUB R2,R2 -> R1=5 after 3 instructions. After SUB, R2=0 and zero_flag=1.
- ADDI wrap: R0=255 via LI/SHL chain, then ADDI R0,1 -> R0=0, zero_flag=1.
- ST R3→[R1]=5, then LD R0,[R1] -> R0 equals R3 and mem[5] is updated.
- Jumps:
  - JZ with zero_flag=1 -> PC=target.
  - JZ with zero_flag=0 -> PC=PC+1.
  - JMP to 0 -> loop re-executes.
- HLT at address 31 -> PC, registers and IR are unchanged over 3 further instruction periods (12 clocks), and reg_write_en stays 0.
